// File: rtl/servo_pos_ctrl.sv
// servo_pos_ctrl: debounced two-button servo position stepper with frame-aligned control updates.
// Optional auto-repeat on held buttons is compiled in with SERVO_AUTO_REPEAT_EN.
module servo_pos_ctrl #(
  parameter int DEBOUNCE_CYC = 500_000,
  parameter int STEP         = 5_000,
  parameter int MAX_POS      = 50_000,
  parameter int CENTER       = 25_000,
  parameter int REPEAT_DLY   = 25_000_000,
  parameter int REPEAT_RATE  = 5_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        button_R,
  input  logic        button_L,
  input  logic        frame_start,
  output logic [17:0] control,
  output logic        control_upd,
  output logic        at_min,
  output logic        at_max
);
  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYC - 1);
  localparam logic [18:0] STEP19 = 19'(STEP);
  localparam logic [18:0] MAX19 = 19'(MAX_POS);
  logic [1:0] s1, s2, db, db_d, arm, press;
  logic [CW-1:0] cnt [2];
  logic [17:0] target, up_val, dn_val;
  logic [18:0] sum, diff;
  logic frame_d, both, inc, dec, rep_inc, rep_dec;
  // Index 0 is R, 1 is L; a button is armed only after a full debounced release, so a level held through reset never steps
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1 <= '1;
      s2 <= '1;
      db <= '1;
      db_d <= '1;
      arm <= '0;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      s1 <= {button_L, button_R};
      s2 <= s1;
      db_d <= db;
      for (int i = 0; i < 2; i++)
        if (!arm[i]) begin
          if (!s2[i]) cnt[i] <= '0;
          else if (cnt[i] == DB_LAST) begin
            arm[i] <= 1'b1;
            cnt[i] <= '0;
          end else cnt[i] <= cnt[i] + 1'b1;
        end else if (s2[i] != db[i]) begin
          if (cnt[i] == DB_LAST) begin
            db[i] <= s2[i];
            cnt[i] <= '0;
          end else cnt[i] <= cnt[i] + 1'b1;
        end else cnt[i] <= '0;
    end
  always_comb begin
    press = db_d & ~db;
    both = ~db[0] & ~db[1];
    inc = press[0] & ~both;
    dec = press[1] & ~both;
  end
`ifdef SERVO_AUTO_REPEAT_EN
  localparam int RMAX = REPEAT_DLY > REPEAT_RATE ? REPEAT_DLY : REPEAT_RATE;
  localparam int RW = $clog2(RMAX + 1);
  localparam logic [1:0] IDLE = 2'd0, HOLD = 2'd1, REPEAT = 2'd2;
  logic [1:0] state;
  logic dir, held, fire;
  logic [RW-1:0] rcnt;
  always_comb begin
    held = (state != IDLE) & ~both & ~db[dir];
    fire = held & (rcnt == (state == HOLD ? RW'(REPEAT_DLY - 1) : RW'(REPEAT_RATE - 1)));
    rep_inc = fire & ~dir;
    rep_dec = fire & dir;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      dir <= 1'b0;
      rcnt <= '0;
    end else if (state == IDLE) begin
      rcnt <= '0;
      if (inc | dec) begin
        state <= HOLD;
        dir <= dec;
      end
    end else if (!held) begin
      state <= IDLE;
      rcnt <= '0;
    end else if (fire) begin
      state <= REPEAT;
      rcnt <= '0;
    end else rcnt <= rcnt + 1'b1;
`else
  always_comb begin
    rep_inc = 1'b0;
    rep_dec = 1'b0;
  end
`endif
  always_comb begin
    sum = {1'b0, target} + STEP19;
    diff = {1'b0, target} - STEP19;
    up_val = sum > MAX19 ? MAX19[17:0] : sum[17:0];
    dn_val = {1'b0, target} < STEP19 ? '0 : diff[17:0];
    at_min = target == '0;
    at_max = target == MAX19[17:0];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      target <= 18'(CENTER);
      control <= 18'(CENTER);
      control_upd <= 1'b0;
      frame_d <= 1'b0;
    end else begin
      target <= (inc | rep_inc) ? up_val : (dec | rep_dec) ? dn_val : target;
      frame_d <= frame_start;
      control_upd <= frame_d && target != control;
      if (frame_d && target != control) control <= target;
    end
endmodule

// File: doc/servo_pos_ctrl.md
SERVO_POS_CTRL -- requirements
Module: servo_pos_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYC, default 500_000, meaning consecutive stable samples needed to accept a button level (10 ms at 50 MHz).
REQ-002 SHALL have parameter STEP, default 5_000, meaning position change per accepted step (0.1 ms of pulse width).
REQ-003 SHALL have parameter MAX_POS, default 50_000, meaning upper position limit; the lower limit is 0.
REQ-004 SHALL have parameter CENTER, default 25_000, meaning position loaded at reset.
REQ-005 SHALL have parameter REPEAT_DLY, default 25_000_000, meaning hold time before auto-repeat starts.
REQ-006 SHALL have parameter REPEAT_RATE, default 5_000_000, meaning cycles between auto-repeat steps.
REQ-007 SHALL have port clk, input, 1 bit: 50 MHz system clock, rising edge.
REQ-008 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-009 SHALL have port button_R, input, 1 bit: active-low, asynchronous; a press increments the position.
REQ-010 SHALL have port button_L, input, 1 bit: active-low, asynchronous; a press decrements the position.
REQ-011 SHALL have port frame_start, input, 1 bit: one-cycle pulse from the PWM stage at the 20 ms period wrap.
REQ-012 SHALL have port control, output, 18 bits: pulse-width offset consumed by the PWM stage.
REQ-013 SHALL have port control_upd, output, 1 bit: one-cycle pulse when control changes.
REQ-014 SHALL have ports at_min and at_max, outputs, 1 bit each: target equals 0 or equals MAX_POS.

Function
REQ-015 SHALL pass each button through a 2-flop synchronizer before any other logic.
REQ-016 SHALL accept a new debounced level only after DEBOUNCE_CYC consecutive identical synchronized samples; any differing sample restarts the count.
REQ-017 SHALL generate a step request on a debounced high-to-low transition (press), latency DEBOUNCE_CYC+3 cycles from the pin edge.
REQ-018 SHALL update an internal target register on a step request:
  - R: target = min(target+STEP, MAX_POS).
  - L: target = max(target-STEP, 0).
  - Arithmetic is 19 bits wide, so there is no wrap-around.
REQ-019 SHALL discard step requests while both debounced buttons are pressed, and shall cancel any auto-repeat in progress.
REQ-020 SHALL ignore a request that would not change target (already saturated); at_min and at_max reflect target combinationally from its register.
REQ-021 SHALL copy target to control only in the cycle after frame_start, and only when target differs from control; control_upd pulses in that same cycle.
REQ-022 SHALL merge multiple steps between frames, so control jumps directly to the latest target.
REQ-023 SHALL apply a step request in the same cycle as frame_start to target first; the next cycle's copy reflects it.

Reset
REQ-024 SHALL, asynchronously on rst_n low, set:
  - target and control to CENTER.
  - control_upd to 0.
  - synchronizers and debounced levels to 1 (released).
  - counters to 0; repeat FSM to IDLE.
REQ-025 SHALL, on reset asserted mid-press, require a full new debounce and press after release of reset; no step is generated from the held level.

Configuration
REQ-026 SHALL compile auto-repeat only when macro SERVO_AUTO_REPEAT_EN is defined.
REQ-027 SHALL implement the auto-repeat FSM as IDLE -> HOLD on press; HOLD -> REPEAT after REPEAT_DLY cycles held; REPEAT issues one step every REPEAT_RATE cycles; any release or both-pressed -> IDLE.
REQ-028 SHALL, without SERVO_AUTO_REPEAT_EN, exclude the FSM and its counters, producing exactly one step per press regardless of hold time.

Verification
REQ-029 SHALL cover debounce (DEBOUNCE_CYC=8): a button_R glitch low for 5 cycles -> no step; low for 20 cycles -> target 25_000->30_000.
REQ-030 SHALL cover frame gating: step at cycle 100 with frame_start at cycle 400 -> control unchanged until cycle 401, then 30_000 with a 1-cycle control_upd.
REQ-031 SHALL cover saturation: 6 R presses from 25_000 -> control 50_000 and at_max=1; a further R press -> no change and no control_upd.
REQ-032 SHALL cover simultaneous press: R and L low together for 50 cycles -> target unchanged, no control_upd.
REQ-033 SHALL cover auto-repeat (macro defined, REPEAT_DLY=100, REPEAT_RATE=20): L held 200 cycles -> steps at press, press+100, +120, +140, ...; macro undefined -> exactly one step.
REQ-034 SHALL cover reset: rst_n low mid-repeat -> control=25_000 immediately (asynchronously), FSM IDLE, no step until release and re-press.
